rtc_timestamp_capture: RTL and testbench
========================================

Name: rtc_timestamp_capture

Overview:
- Consumes the free-running RTC time bus (rtc_sec / rtc_nsec) and timestamps edges on an asynchronous event input.
- Each captured timestamp is queued in a FIFO and presented as a 64-bit AXI4-Stream master for DMA or CPU readout.
- Sits directly downstream of the RTC core. Clocked in the same aclk domain, so the time bus needs no CDC.

Parameters:
- FIFO_DEPTH, 16, number of timestamp entries; power of 2, 4..256.
- SYNC_STAGES, 2, synchroniser flops on event_in; 2..4.
- EDGE_SEL, 0, capture edge: 0 = rising, 1 = falling, 2 = both.
- LAT_NS, 24, latency compensation in ns; < 1_000_000_000; used only with the optional feature.

Ports:
- aclk  in  1  clock, same domain as the RTC.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- event_in  in  1  asynchronous event input.
- rtc_sec  in  32  RTC seconds.
- rtc_nsec  in  30  RTC nanoseconds, 0..999_999_999.
- m_ts_tdata  out  64  {sec[31:0], 2'b00, nsec[29:0]}.
- m_ts_tvalid  out  1  timestamp available.
- m_ts_tready  in  1  downstream accept.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow_cnt  out  16  number of dropped events, saturating.
- overflow_clr  in  1  single-cycle clear of overflow_cnt.

Behaviour:
- Reset and clocking:
  - Single clock aclk; reset areset is synchronous, active-high.
  - While areset = 1: m_ts_tvalid = 0, m_ts_tdata = 0, fifo_count = 0, overflow_cnt = 0.
  - Sync chain and edge-history flop clear to 0; FIFO pointers clear.
  - Asserting reset mid-operation flushes all queued entries, with no partial output.
- Arming:
  - After reset release, edge detection is suppressed for SYNC_STAGES+1 cycles.
  - A level already present on event_in at release therefore produces no capture.
- Detection:
  - event_in passes through SYNC_STAGES flops, then a one-flop history.
  - A detection occurs in cycle N when sync_out and hist differ in the direction selected by EDGE_SEL.
  - Input-edge-to-detect latency is SYNC_STAGES+1 cycles.
- Capture:
  - In detect cycle N with enable = 1, {rtc_sec, rtc_nsec} as present in cycle N is written to the FIFO at the N clock edge.
  - m_ts_tvalid is high from cycle N+1 when the FIFO was empty.
  - enable = 0: detections are ignored and not counted as overflow. The edge history keeps tracking, so re-enabling never creates a spurious edge.
  - Queued entries continue to drain regardless of enable.
- Output handshake (AXI4-Stream rules):
  - tvalid = (count != 0).
  - An entry pops when tvalid && tready.
  - tdata is the FIFO head and stays stable while tvalid && !tready.
  - Output order is capture order.
- Full:
  - A detection while count == FIFO_DEPTH with no pop in the same cycle is dropped, and overflow_cnt increments.
  - Full with a simultaneous pop: the write is accepted and count stays unchanged.
- Empty with a simultaneous write: no pop; tvalid rises next cycle.
- Pointers wrap modulo FIFO_DEPTH. count range is 0..FIFO_DEPTH.
- overflow_cnt saturates at 0xFFFF.
  - overflow_clr alone sets it to 0.
  - overflow_clr together with a drop sets it to 1.
- rtc_sec and rtc_nsec are used as sampled; no validity or range check.

Optional Feature:
- Macro: RTC_TS_LATENCY_COMP_EN.
- Defined: stored time = sampled time − LAT_NS.
  - If rtc_nsec >= LAT_NS: nsec = rtc_nsec − LAT_NS, sec unchanged.
  - Else: nsec = rtc_nsec + 1_000_000_000 − LAT_NS, sec = rtc_sec − 1 (mod 2^32, so 0 wraps to 0xFFFFFFFF).
  - Computed combinationally before the FIFO write; latency is unchanged.
- Not defined: the raw sample is stored and LAT_NS is ignored.

Test Plan:
- Single rising edge: EDGE_SEL = 0, SYNC_STAGES = 2, rtc = (5 s, 123 ns) in the detect cycle, tready = 1 → exactly one beat, tdata = 0x00000005_0000007B, detect 3 cycles after the input edge, tvalid one cycle after detect.
- Fill and drop: FIFO_DEPTH = 4, tready = 0, 6 edges → fifo_count = 4, overflow_cnt = 2; drain yields the first 4 timestamps in order; overflow_clr then reads 0.
- Full plus pop: an edge arrives in the same cycle as a pop at count = 4 → no overflow, count stays 4, new entry appears last.
- Enable and reset gating: event_in high through reset release → no capture. enable toggled low during an edge → no capture and no overflow. Reset asserted with 3 entries queued → tvalid = 0 next cycle, count = 0.
- Backpressure: tready held low 10 cycles with tvalid = 1 → tdata is bit-stable throughout; EDGE_SEL = 2 with a pulse gives 2 entries.
- With RTC_TS_LATENCY_COMP_EN, LAT_NS = 24: (7 s, 10 ns) → (6 s, 999_999_986 ns); (0 s, 0 ns) → (0xFFFFFFFF s, 999_999_976 ns); (7 s, 100 ns) → (7 s, 76 ns).

Source files
------------

// File: rtl/rtc_timestamp_capture_if.sv
// rtc_timestamp_capture_if: AXI4-Stream timestamp channel.
// tdata = {sec[31:0], 2'b00, nsec[29:0]}.
interface rtc_timestamp_capture_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/rtc_timestamp_capture.sv
// rtc_timestamp_capture: timestamps edges on event_in from the RTC bus and
// queues them for AXI4-Stream readout. Option macro: RTC_TS_LATENCY_COMP_EN.
module rtc_timestamp_capture #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_SEL    = 0,
    parameter int LAT_NS      = 24
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         enable,
    input  logic                         event_in,
    input  logic [31:0]                  rtc_sec,
    input  logic [29:0]                  rtc_nsec,
    rtc_timestamp_capture_if.master      m_ts,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [15:0]                  overflow_cnt,
    input  logic                         overflow_clr
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int ARMW  = $clog2(ARM_N + 1);

    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 4..256");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (EDGE_SEL < 0 || EDGE_SEL > 2) begin : g_bad_edge
        $error("EDGE_SEL must be 0..2");
    end
    if (LAT_NS < 0 || LAT_NS >= 1000000000) begin : g_bad_lat
        $error("LAT_NS must be below one second");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [ARMW-1:0]        arm_q, arm_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [15:0]            ovf_q, ovf_d;
    logic [61:0]            mem_q [FIFO_DEPTH];

    logic        sync_out, rise, fall, armed, det;
    logic        valid, full, pop, push, drop;
    logic [31:0] ts_sec;
    logic [29:0] ts_nsec;

    // Edge detection on the synchronised input, masked until the chain is primed.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        rise     = sync_out & ~hist_q;
        fall     = ~sync_out & hist_q;
        armed    = (arm_q == ARMW'(ARM_N));
        if (EDGE_SEL == 0) begin
            det = armed & rise;
        end else if (EDGE_SEL == 1) begin
            det = armed & fall;
        end else begin
            det = armed & (rise | fall);
        end
    end

`ifdef RTC_TS_LATENCY_COMP_EN
    localparam logic [29:0] LAT_V   = 30'(LAT_NS);
    localparam logic [29:0] NS_WRAP = 30'(1000000000 - LAT_NS);

    // Back-date the sample by the input path latency, borrowing a second if needed.
    always_comb begin
        if (rtc_nsec >= LAT_V) begin
            ts_sec  = rtc_sec;
            ts_nsec = rtc_nsec - LAT_V;
        end else begin
            ts_sec  = rtc_sec - 32'd1;
            ts_nsec = rtc_nsec + NS_WRAP;
        end
    end
`else
    // Raw sample is stored as-is.
    always_comb begin
        ts_sec  = rtc_sec;
        ts_nsec = rtc_nsec;
    end
`endif

    // FIFO bookkeeping: pop first, so a full queue can accept while draining.
    always_comb begin
        valid    = ~areset & (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = valid & m_ts.tready;
        push     = det & enable & (~full | pop);
        drop     = det & enable & full & ~pop;
        sync_d   = {sync_q[SYNC_STAGES-2:0], event_in};
        hist_d   = sync_out;
        arm_d    = armed ? arm_q : arm_q + ARMW'(1);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = overflow_clr ? 16'd0 : ovf_q;
        if (drop && ovf_d != 16'hFFFF) begin
            ovf_d = ovf_d + 16'd1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            arm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            arm_q    <= arm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; occupancy alone qualifies the head entry.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_sec, ts_nsec};
        end
    end

    // Outputs are forced to zero while reset is held.
    always_comb begin
        m_ts.tvalid = valid;
        m_ts.tdata  = '0;
        if (valid) begin
            m_ts.tdata = {mem_q[rd_ptr_q][61:30], 2'b00,
                          mem_q[rd_ptr_q][29:0]};
        end
        fifo_count   = areset ? '0 : count_q;
        overflow_cnt = areset ? '0 : ovf_q;
    end
endmodule

// File: tb/tb_rtc_timestamp_capture.sv
// tb_rtc_timestamp_capture: two configurations (rising/depth 4/2 stages and
// both-edge/depth 8/3 stages) checked against a timestamp-queue model.
module tb_rtc_timestamp_capture;
    localparam int LAT = 24;

    logic        clk = 1'b0;
    logic        areset, enable, event_in, tready, ovf_clr;
    logic [31:0] rtc_sec;
    logic [29:0] rtc_nsec;
    logic [2:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] ovf_a, ovf_b;

    int n_chk = 0;
    int n_fail = 0;

    rtc_timestamp_capture_if ifa ();
    rtc_timestamp_capture_if ifb ();
    assign ifa.tready = tready;
    assign ifb.tready = tready;

    rtc_timestamp_capture #(
        .FIFO_DEPTH(4), .SYNC_STAGES(2), .EDGE_SEL(0), .LAT_NS(LAT)
    ) dut_a (
        .aclk(clk), .areset(areset), .enable(enable), .event_in(event_in),
        .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec), .m_ts(ifa),
        .fifo_count(cnt_a), .overflow_cnt(ovf_a), .overflow_clr(ovf_clr)
    );

    rtc_timestamp_capture #(
        .FIFO_DEPTH(8), .SYNC_STAGES(3), .EDGE_SEL(2), .LAT_NS(LAT)
    ) dut_b (
        .aclk(clk), .areset(areset), .enable(enable), .event_in(event_in),
        .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec), .m_ts(ifb),
        .fifo_count(cnt_b), .overflow_cnt(ovf_b), .overflow_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: event samples since reset release, queued stamps.
    bit          evq[$];
    logic [61:0] qa[$];
    logic [61:0] qb[$];
    int          ova, ovb;
    bit          free_run = 1'b1;

    // An edge on event_in is seen s+1 clocks later; nothing before arming.
    function automatic bit det(int esel, int s);
        int n;
        bit cur, prev;
        n = evq.size();
        if (n < s + 1) return 1'b0;
        cur  = evq[n - s];
        prev = evq[n - s - 1];
        if (esel == 0) return cur & !prev;
        if (esel == 1) return !cur & prev;
        return cur ^ prev;
    endfunction

    function automatic logic [61:0] stamp(logic [31:0] s, logic [29:0] ns);
`ifdef RTC_TS_LATENCY_COMP_EN
        longint t;
        longint ts;
        longint tn;
        t = longint'(s) * 64'sd1000000000 + longint'(ns) - LAT;
        if (t < 0) t = t + 64'sd4294967296 * 64'sd1000000000;
        ts = t / 64'sd1000000000;
        tn = t % 64'sd1000000000;
        return {ts[31:0], tn[29:0]};
`else
        return {s, ns};
`endif
    endfunction

    function automatic logic [63:0] head(logic [61:0] x);
        return {x[61:30], 2'b00, x[29:0]};
    endfunction

    task automatic cyc();
        bit ev, en, rdy, clr, rst, da, db, fa, fb, pa, pb;
        logic [61:0] ts;
        ev  = event_in;
        en  = enable;
        rdy = tready;
        clr = ovf_clr;
        rst = areset;
        ts  = stamp(rtc_sec, rtc_nsec);
        @(posedge clk);
        if (rst) begin
            evq.delete();
            qa.delete();
            qb.delete();
            ova = 0;
            ovb = 0;
        end else begin
            da = det(0, 2) && en;
            db = det(2, 3) && en;
            fa = (qa.size() == 4);
            fb = (qb.size() == 8);
            pa = rdy && qa.size() != 0;
            pb = rdy && qb.size() != 0;
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (clr) begin
                ova = 0;
                ovb = 0;
            end
            if (da) begin
                if (!fa || pa) qa.push_back(ts);
                else if (ova < 65535) ova++;
            end
            if (db) begin
                if (!fb || pb) qb.push_back(ts);
                else if (ovb < 65535) ovb++;
            end
            evq.push_back(ev);
        end
        #1;
        if (free_run) begin
            if (rtc_nsec >= 30'd999999960) begin
                rtc_nsec = rtc_nsec - 30'd999999960;
                rtc_sec  = rtc_sec + 32'd1;
            end else begin
                rtc_nsec = rtc_nsec + 30'd40;
            end
        end
    endtask

    task automatic pulse();
        event_in = 1'b1;
        repeat (2) cyc();
        event_in = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        areset = 1'b1; enable = 1'b1; event_in = 1'b1;
        tready = 1'b0; ovf_clr = 1'b0;
        repeat (3) cyc();
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_tvalid_a: got %b want 0", ifa.tvalid); end
        n_chk++; if (ifa.tdata !== 64'h0) begin n_fail++;
            $display("FAIL reset_tdata_a: got %h want 0", ifa.tdata); end
        n_chk++; if (cnt_a !== 3'd0) begin n_fail++;
            $display("FAIL reset_count_a: got %0d want 0", cnt_a); end
        n_chk++; if (ovf_a !== 16'd0) begin n_fail++;
            $display("FAIL reset_ovf_a: got %0d want 0", ovf_a); end
        n_chk++; if (ifb.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL reset_tvalid_b: got %b want 0", ifb.tvalid); end
        areset = 1'b0;
        repeat (12) cyc();
        n_chk++; if (cnt_a !== 3'd0) begin n_fail++;
            $display("FAIL arm_level_a: got %0d want 0", cnt_a); end
        n_chk++; if (cnt_b !== 4'd0) begin n_fail++;
            $display("FAIL arm_level_b: got %0d want 0", cnt_b); end
    endtask

    task automatic test_single_edge();
        logic [63:0] exp;
`ifdef RTC_TS_LATENCY_COMP_EN
        exp = 64'h00000005_00000063;
`else
        exp = 64'h00000005_0000007B;
`endif
        event_in = 1'b0; tready = 1'b1;
        repeat (8) cyc();
        event_in = 1'b1;
        cyc();
        cyc();
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL edge_early_a: got %b want 0", ifa.tvalid); end
        free_run = 1'b0;
        rtc_sec = 32'd5; rtc_nsec = 30'd123;
        cyc();
        n_chk++; if (ifa.tvalid !== 1'b1) begin n_fail++;
            $display("FAIL edge_tvalid_a: got %b want 1", ifa.tvalid); end
        n_chk++; if (ifa.tdata !== exp) begin n_fail++;
            $display("FAIL edge_tdata_a: got %h want %h", ifa.tdata, exp); end
        cyc();
        free_run = 1'b1;
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL edge_one_beat_a: got %b want 0", ifa.tvalid); end
        repeat (3) cyc();
        n_chk++; if (cnt_a !== 3'd0) begin n_fail++;
            $display("FAIL edge_count_a: got %0d want 0", cnt_a); end
    endtask

    task automatic test_fill_drop();
        logic [61:0] exp[$];
        tready = 1'b0; event_in = 1'b0;
        repeat (4) cyc();
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        repeat (6) pulse();
        repeat (4) cyc();
        n_chk++; if (cnt_a !== 3'd4) begin n_fail++;
            $display("FAIL fill_count_a: got %0d want 4", cnt_a); end
        n_chk++; if (ovf_a !== 16'd2) begin n_fail++;
            $display("FAIL fill_ovf_a: got %0d want 2", ovf_a); end
        exp = qa;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ifa.tdata !== head(exp[i])) begin n_fail++;
                $display("FAIL fill_drain_a[%0d]: got %h want %h",
                         i, ifa.tdata, head(exp[i])); end
            cyc();
        end
        tready = 1'b0;
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL fill_empty_a: got %b want 0", ifa.tvalid); end
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        n_chk++; if (ovf_a !== 16'd0) begin n_fail++;
            $display("FAIL ovf_clr_a: got %0d want 0", ovf_a); end
    endtask

    task automatic test_full_pop();
        logic [61:0] exp[$];
        tready = 1'b0;
        repeat (4) pulse();
        repeat (3) cyc();
        n_chk++; if (cnt_a !== 3'd4) begin n_fail++;
            $display("FAIL fullpop_pre_a: got %0d want 4", cnt_a); end
        event_in = 1'b1;
        cyc();
        cyc();
        free_run = 1'b0;
        rtc_sec = 32'h77; rtc_nsec = 30'd777; tready = 1'b1;
        cyc();
        tready = 1'b0; free_run = 1'b1; event_in = 1'b0;
        n_chk++; if (cnt_a !== 3'd4) begin n_fail++;
            $display("FAIL fullpop_count_a: got %0d want 4", cnt_a); end
        n_chk++; if (ovf_a !== 16'd0) begin n_fail++;
            $display("FAIL fullpop_ovf_a: got %0d want 0", ovf_a); end
        exp = qa;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (ifa.tdata !== head(exp[i])) begin n_fail++;
                $display("FAIL fullpop_drain_a[%0d]: got %h want %h",
                         i, ifa.tdata, head(exp[i])); end
            if (i == 3) begin
                n_chk++;
                if (ifa.tdata !== head(stamp(32'h77, 30'd777))) begin n_fail++;
                    $display("FAIL fullpop_last_a: got %h want %h",
                             ifa.tdata, head(stamp(32'h77, 30'd777))); end
            end
            cyc();
        end
        tready = 1'b0;
    endtask

    task automatic test_enable_gating();
        tready = 1'b1; event_in = 1'b0;
        repeat (8) cyc();
        tready = 1'b0;
        repeat (4) pulse();
        repeat (3) cyc();
        enable = 1'b0;
        event_in = 1'b1; repeat (6) cyc();
        event_in = 1'b0; repeat (6) cyc();
        n_chk++; if (cnt_a !== 3'd4) begin n_fail++;
            $display("FAIL gate_count_a: got %0d want 4", cnt_a); end
        n_chk++; if (ovf_a !== 16'd0) begin n_fail++;
            $display("FAIL gate_ovf_a: got %0d want 0", ovf_a); end
        event_in = 1'b1; repeat (6) cyc();
        enable = 1'b1; repeat (6) cyc();
        n_chk++; if (ovf_a !== 16'd0) begin n_fail++;
            $display("FAIL reenable_ovf_a: got %0d want 0", ovf_a); end
        event_in = 1'b0; tready = 1'b1; cyc(); tready = 1'b0;
        n_chk++; if (cnt_a !== 3'd3) begin n_fail++;
            $display("FAIL flush_pre_a: got %0d want 3", cnt_a); end
        areset = 1'b1; cyc();
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL flush_tvalid_a: got %b want 0", ifa.tvalid); end
        areset = 1'b0; repeat (6) cyc();
        n_chk++; if (cnt_a !== 3'd0) begin n_fail++;
            $display("FAIL flush_count_a: got %0d want 0", cnt_a); end
        n_chk++; if (ifa.tvalid !== 1'b0) begin n_fail++;
            $display("FAIL flush_after_a: got %b want 0", ifa.tvalid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] hold_a, hold_b;
        event_in = 1'b0; tready = 1'b1;
        repeat (10) cyc();
        tready = 1'b0;
        event_in = 1'b1; repeat (3) cyc();
        event_in = 1'b0; repeat (8) cyc();
        n_chk++; if (cnt_b !== 4'd2) begin n_fail++;
            $display("FAIL both_edge_count_b: got %0d want 2", cnt_b); end
        n_chk++; if (cnt_a !== 3'd1) begin n_fail++;
            $display("FAIL rise_only_count_a: got %0d want 1", cnt_a); end
        hold_a = head(qa[0]);
        hold_b = head(qb[0]);
        repeat (10) begin
            cyc();
            n_chk++; if (ifa.tvalid !== 1'b1 || ifa.tdata !== hold_a) begin
                n_fail++;
                $display("FAIL stall_a: got %b/%h want 1/%h",
                         ifa.tvalid, ifa.tdata, hold_a); end
            n_chk++; if (ifb.tvalid !== 1'b1 || ifb.tdata !== hold_b) begin
                n_fail++;
                $display("FAIL stall_b: got %b/%h want 1/%h",
                         ifb.tvalid, ifb.tdata, hold_b); end
        end
        tready = 1'b1; repeat (10) cyc();
    endtask

    task automatic test_latency();
        logic [31:0] vs[3];
        logic [29:0] vn[3];
        logic [63:0] exp[3];
        vs[0] = 32'd7; vn[0] = 30'd10;
        vs[1] = 32'd0; vn[1] = 30'd0;
        vs[2] = 32'd7; vn[2] = 30'd100;
`ifdef RTC_TS_LATENCY_COMP_EN
        exp[0] = {32'd6, 2'b00, 30'd999999986};
        exp[1] = {32'hFFFFFFFF, 2'b00, 30'd999999976};
        exp[2] = {32'd7, 2'b00, 30'd76};
`else
        exp[0] = {32'd7, 2'b00, 30'd10};
        exp[1] = {32'd0, 2'b00, 30'd0};
        exp[2] = {32'd7, 2'b00, 30'd100};
`endif
        tready = 1'b1; event_in = 1'b0;
        repeat (8) cyc();
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            event_in = 1'b1; cyc(); cyc();
            free_run = 1'b0; rtc_sec = vs[i]; rtc_nsec = vn[i];
            cyc();
            free_run = 1'b1; event_in = 1'b0;
            repeat (3) cyc();
        end
        n_chk++; if (cnt_a !== 3'd3) begin n_fail++;
            $display("FAIL lat_count_a: got %0d want 3", cnt_a); end
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (ifa.tdata !== exp[i]) begin n_fail++;
                $display("FAIL lat_tdata_a[%0d]: got %h want %h",
                         i, ifa.tdata, exp[i]); end
            cyc();
        end
        repeat (10) cyc();
    endtask

    task automatic test_random();
        logic [63:0] ea, eb;
        for (int i = 0; i < 3000; i++) begin
            ea = (!areset && qa.size() != 0) ? head(qa[0]) : 64'h0;
            eb = (!areset && qb.size() != 0) ? head(qb[0]) : 64'h0;
            n_chk++; if (ifa.tvalid !== (!areset && qa.size() != 0)) begin
                n_fail++; $display("FAIL rnd_tvalid_a @%0d: got %b", i, ifa.tvalid); end
            n_chk++; if (ifa.tdata !== ea) begin n_fail++;
                $display("FAIL rnd_tdata_a @%0d: got %h want %h", i, ifa.tdata, ea); end
            n_chk++; if (cnt_a !== 3'(areset ? 0 : qa.size())) begin n_fail++;
                $display("FAIL rnd_count_a @%0d: got %0d want %0d", i, cnt_a, qa.size()); end
            n_chk++; if (ovf_a !== 16'(areset ? 0 : ova)) begin n_fail++;
                $display("FAIL rnd_ovf_a @%0d: got %0d want %0d", i, ovf_a, ova); end
            n_chk++; if (ifb.tvalid !== (!areset && qb.size() != 0)) begin
                n_fail++; $display("FAIL rnd_tvalid_b @%0d: got %b", i, ifb.tvalid); end
            n_chk++; if (ifb.tdata !== eb) begin n_fail++;
                $display("FAIL rnd_tdata_b @%0d: got %h want %h", i, ifb.tdata, eb); end
            n_chk++; if (cnt_b !== 4'(areset ? 0 : qb.size())) begin n_fail++;
                $display("FAIL rnd_count_b @%0d: got %0d want %0d", i, cnt_b, qb.size()); end
            n_chk++; if (ovf_b !== 16'(areset ? 0 : ovb)) begin n_fail++;
                $display("FAIL rnd_ovf_b @%0d: got %0d want %0d", i, ovf_b, ovb); end
            if ($urandom_range(3) == 0) event_in = ~event_in;
            enable  = ($urandom_range(9) != 0);
            tready  = ($urandom_range(9) < (((i / 400) % 2) ? 2 : 8));
            ovf_clr = ($urandom_range(49) == 0);
            areset  = ($urandom_range(399) == 0);
            if ($urandom_range(19) == 0) begin
                rtc_sec  = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom);
                rtc_nsec = ($urandom_range(1) == 0) ? 30'($urandom_range(0, 40))
                                                    : 30'($urandom_range(0, 999999999));
            end
            cyc();
        end
        areset = 1'b0; ovf_clr = 1'b0; enable = 1'b1;
    endtask

    initial begin
        areset   = 1'b1;
        enable   = 1'b1;
        event_in = 1'b0;
        tready   = 1'b0;
        ovf_clr  = 1'b0;
        rtc_sec  = $urandom;
        rtc_nsec = 30'($urandom_range(0, 999999999));
        test_reset();
        test_single_edge();
        test_fill_drop();
        test_full_pop();
        test_enable_gating();
        test_backpressure();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
